// File: rtl/dpram_param_pkg.sv
// dpram_param_pkg: shared constants, clear-FSM state type and parity helper
// for the dpram_param true dual-port RAM and its per-port read path.
package dpram_param_pkg;

  localparam int READ_BYPASS = 0;
  localparam int READ_PIPE   = 1;

  localparam int WR_NORMAL  = 0;
  localparam int WR_THROUGH = 1;
  localparam int WR_RBW     = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  // Even parity over a word zero-extended to the widest supported width.
  function automatic logic even_par(input logic [35:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/dpram_param_port.sv
// dpram_param_port: one port's read path (stage-1 capture, WRITE_MODE select,
// optional output register, valid, parity check).
// Ports: clk, rst, busy, ce (busy-masked), we, oce, q (array word at ad),
//   wd (word being written), dout, valid, perr (DPRAM_PARAM_PARITY_EN only).
module dpram_param_port
  import dpram_param_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int WORD_W     = 8,
  parameter int READ_MODE  = 1,
  parameter int WRITE_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              busy,
  input  logic              ce,
  input  logic              we,
  input  logic              oce,
  input  logic [WORD_W-1:0] q,
  input  logic [WORD_W-1:0] wd,
  output logic [DATA_W-1:0] dout,
  output logic              valid
`ifdef DPRAM_PARAM_PARITY_EN
  ,
  output logic              perr
`endif
);

  logic [WORD_W-1:0] s1_word;
  logic              s1_valid;
  logic [WORD_W-1:0] out_word;
  logic              out_valid;
  logic [WORD_W-1:0] sel_word;
  logic              sel_valid;

  // q is sampled before the array write of the same edge lands,
  // so reads and read-before-write both see the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_word  <= '0;
      s1_valid <= 1'b0;
    end else if (ce && !we) begin
      s1_word  <= q;
      s1_valid <= 1'b1;
    end else if (ce && WRITE_MODE == WR_THROUGH) begin
      s1_word  <= wd;
      s1_valid <= 1'b1;
    end else if (ce && WRITE_MODE == WR_RBW) begin
      s1_word  <= q;
      s1_valid <= 1'b1;
    end else begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_word  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= oce & s1_valid;
      if (oce) out_word <= s1_word;
    end
  end

  assign sel_word  = (READ_MODE == READ_PIPE) ? out_word : s1_word;
  assign sel_valid = (READ_MODE == READ_PIPE) ? out_valid : s1_valid;

  assign dout  = sel_word[DATA_W-1:0];
  assign valid = sel_valid & ~busy;

`ifdef DPRAM_PARAM_PARITY_EN
  // Stored word carries even parity, so a good word XORs to zero.
  assign perr = valid & (^sel_word);
`endif

endmodule

// File: rtl/dpram_param.sv
// dpram_param: true dual-port RAM with clear engine and collision flag.
// Ports: clk, reset, clr_start, busy, cea/ceb, ocea/oceb, wrea/wreb,
//   ada/adb, dina/dinb, douta/doutb, valida/validb, coll;
//   perra/perrb when DPRAM_PARAM_PARITY_EN is defined.
module dpram_param
  import dpram_param_pkg::*;
#(
  parameter int              DATA_W     = 8,
  parameter int              ADDR_W     = 11,
  parameter int              READ_MODE  = 1,
  parameter int              WRITE_MODE = 0,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_start,
  output logic              busy,
  input  logic              cea,
  input  logic              ceb,
  input  logic              ocea,
  input  logic              oceb,
  input  logic              wrea,
  input  logic              wreb,
  input  logic [ADDR_W-1:0] ada,
  input  logic [ADDR_W-1:0] adb,
  input  logic [DATA_W-1:0] dina,
  input  logic [DATA_W-1:0] dinb,
  output logic [DATA_W-1:0] douta,
  output logic [DATA_W-1:0] doutb,
  output logic              valida,
  output logic              validb,
  output logic              coll
`ifdef DPRAM_PARAM_PARITY_EN
  ,
  output logic              perra,
  output logic              perrb
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef DPRAM_PARAM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  logic [WORD_W-1:0] mem [DEPTH];

  state_t            state;
  logic [ADDR_W-1:0] cnt;

  logic              acc_a;
  logic              acc_b;
  logic              wr_a;
  logic              wr_b;
  logic [WORD_W-1:0] word_a;
  logic [WORD_W-1:0] word_b;
  logic [WORD_W-1:0] clr_word;
  logic [WORD_W-1:0] qa;
  logic [WORD_W-1:0] qb;

`ifdef DPRAM_PARAM_PARITY_EN
  assign word_a   = {even_par(36'(dina)), dina};
  assign word_b   = {even_par(36'(dinb)), dinb};
  assign clr_word = {even_par(36'(CLEAR_VAL)), CLEAR_VAL};
`else
  assign word_a   = dina;
  assign word_b   = dinb;
  assign clr_word = CLEAR_VAL;
`endif

  assign busy  = (state == CLEAR);
  assign acc_a = cea & ~busy;
  assign acc_b = ceb & ~busy;
  assign wr_a  = acc_a & wrea;
  assign wr_b  = acc_b & wreb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      unique case (state)
        CLEAR: begin
          cnt <= cnt + ADDR_W'(1);
          if (&cnt) state <= IDLE;
        end
        IDLE: begin
          if (clr_start) begin
            state <= CLEAR;
            cnt   <= '0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Port A is written last so it wins a same-address write collision.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[cnt] <= clr_word;
    end else begin
      if (wr_b) mem[adb] <= word_b;
      if (wr_a) mem[ada] <= word_a;
    end
  end

  assign qa = mem[ada];
  assign qb = mem[adb];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) coll <= 1'b0;
    else       coll <= wr_a & wr_b & (ada == adb);
  end

  dpram_param_port #(
    .DATA_W     (DATA_W),
    .WORD_W     (WORD_W),
    .READ_MODE  (READ_MODE),
    .WRITE_MODE (WRITE_MODE)
  ) u_port_a (
    .clk   (clk),
    .rst   (reset),
    .busy  (busy),
    .ce    (acc_a),
    .we    (wrea),
    .oce   (ocea),
    .q     (qa),
    .wd    (word_a),
    .dout  (douta),
    .valid (valida)
`ifdef DPRAM_PARAM_PARITY_EN
    ,
    .perr  (perra)
`endif
  );

  dpram_param_port #(
    .DATA_W     (DATA_W),
    .WORD_W     (WORD_W),
    .READ_MODE  (READ_MODE),
    .WRITE_MODE (WRITE_MODE)
  ) u_port_b (
    .clk   (clk),
    .rst   (reset),
    .busy  (busy),
    .ce    (acc_b),
    .we    (wreb),
    .oce   (oceb),
    .q     (qb),
    .wd    (word_b),
    .dout  (doutb),
    .valid (validb)
`ifdef DPRAM_PARAM_PARITY_EN
    ,
    .perr  (perrb)
`endif
  );

endmodule

// File: tb/tb_dpram_param.sv
// tb_dpram_param: three dpram_param configurations on shared stimulus,
// checked against a behavioural memory/pipeline model.
module tb_dpram_param;

  localparam int DEPTH = 16;
  localparam logic [7:0] CV = 8'hA5;

  logic       clk;
  logic       rst;
  logic       clr_start;
  logic       cea, ceb, ocea, oceb, wrea, wreb;
  logic [3:0] ada, adb;
  logic [7:0] dina, dinb;

  logic [7:0] douta [3];
  logic [7:0] doutb [3];
  logic       valida [3];
  logic       validb [3];
  logic       busy [3];
  logic       coll [3];

  int rmode [3] = '{0, 1, 0};
  int wmode [3] = '{2, 1, 0};

  logic [7:0] mem_m [DEPTH];
  int         clr_left;
  logic [7:0] s1d [3][2];
  logic       s1v [3][2];
  logic [7:0] od  [3][2];
  logic       ov  [3][2];
  logic       coll_m;

  int checks;
  int errors;
  int nb;

  dpram_param #(.DATA_W(8), .ADDR_W(4), .READ_MODE(0),
                .WRITE_MODE(2), .CLEAR_VAL(CV)) u0 (
    .clk(clk), .reset(rst), .clr_start(clr_start), .busy(busy[0]),
    .cea(cea), .ceb(ceb), .ocea(ocea), .oceb(oceb),
    .wrea(wrea), .wreb(wreb), .ada(ada), .adb(adb),
    .dina(dina), .dinb(dinb), .douta(douta[0]), .doutb(doutb[0]),
    .valida(valida[0]), .validb(validb[0]), .coll(coll[0]));

  dpram_param #(.DATA_W(8), .ADDR_W(4), .READ_MODE(1),
                .WRITE_MODE(1), .CLEAR_VAL(CV)) u1 (
    .clk(clk), .reset(rst), .clr_start(clr_start), .busy(busy[1]),
    .cea(cea), .ceb(ceb), .ocea(ocea), .oceb(oceb),
    .wrea(wrea), .wreb(wreb), .ada(ada), .adb(adb),
    .dina(dina), .dinb(dinb), .douta(douta[1]), .doutb(doutb[1]),
    .valida(valida[1]), .validb(validb[1]), .coll(coll[1]));

  dpram_param #(.DATA_W(8), .ADDR_W(4), .READ_MODE(0),
                .WRITE_MODE(0), .CLEAR_VAL(CV)) u2 (
    .clk(clk), .reset(rst), .clr_start(clr_start), .busy(busy[2]),
    .cea(cea), .ceb(ceb), .ocea(ocea), .oceb(oceb),
    .wrea(wrea), .wreb(wreb), .ada(ada), .adb(adb),
    .dina(dina), .dinb(dinb), .douta(douta[2]), .doutb(doutb[2]),
    .valida(valida[2]), .validb(validb[2]), .coll(coll[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic check_all();
    logic bz;
    logic [7:0] ed;
    logic ev;
    bz = (clr_left > 0);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("u%0d busy", d), 32'(busy[d]), 32'(bz));
      chk($sformatf("u%0d coll", d), 32'(coll[d]), 32'(coll_m));
      for (int p = 0; p < 2; p++) begin
        ed = (rmode[d] == 1) ? od[d][p] : s1d[d][p];
        ev = ((rmode[d] == 1) ? ov[d][p] : s1v[d][p]) & ~bz;
        if (p == 0) begin
          chk($sformatf("u%0d douta", d), 32'(douta[d]), 32'(ed));
          chk($sformatf("u%0d valida", d), 32'(valida[d]), 32'(ev));
        end else begin
          chk($sformatf("u%0d doutb", d), 32'(doutb[d]), 32'(ed));
          chk($sformatf("u%0d validb", d), 32'(validb[d]), 32'(ev));
        end
      end
    end
  endtask

  // One clock: predict this edge from the rules, then compare.
  task automatic cyc();
    logic bz;
    logic [7:0] old [2];
    logic [7:0] din [2];
    logic acc [2];
    logic we [2];
    logic oc [2];
    bz = (clr_left > 0);
    old[0] = mem_m[ada]; old[1] = mem_m[adb];
    din[0] = dina; din[1] = dinb;
    acc[0] = cea && !bz; acc[1] = ceb && !bz;
    we[0] = wrea; we[1] = wreb;
    oc[0] = ocea; oc[1] = oceb;
    for (int d = 0; d < 3; d++) begin
      for (int p = 0; p < 2; p++) begin
        if (oc[p]) od[d][p] = s1d[d][p];
        ov[d][p] = oc[p] && s1v[d][p];
        s1v[d][p] = 1'b0;
        if (acc[p]) begin
          if (!we[p]) begin
            s1d[d][p] = old[p]; s1v[d][p] = 1'b1;
          end else if (wmode[d] == 1) begin
            s1d[d][p] = din[p]; s1v[d][p] = 1'b1;
          end else if (wmode[d] == 2) begin
            s1d[d][p] = old[p]; s1v[d][p] = 1'b1;
          end
        end
      end
    end
    coll_m = acc[0] && acc[1] && we[0] && we[1] && (ada == adb);
    if (bz) begin
      mem_m[DEPTH - clr_left] = CV;
      clr_left--;
    end else begin
      if (clr_start) clr_left = DEPTH;
      if (acc[1] && we[1]) mem_m[adb] = dinb;
      if (acc[0] && we[0]) mem_m[ada] = dina;
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    clr_left = DEPTH;
    coll_m = 1'b0;
    for (int d = 0; d < 3; d++)
      for (int p = 0; p < 2; p++) begin
        s1d[d][p] = '0; s1v[d][p] = 1'b0;
        od[d][p] = '0;  ov[d][p] = 1'b0;
      end
    check_all();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_in(input logic ca, input logic wa, input logic [3:0] aa,
                        input logic [7:0] da, input logic cb, input logic wb,
                        input logic [3:0] ab, input logic [7:0] db);
    cea = ca; wrea = wa; ada = aa; dina = da;
    ceb = cb; wreb = wb; adb = ab; dinb = db;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    ocea = 1'b1; oceb = 1'b1; clr_start = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0;
    idle();
    @(negedge clk);
    do_reset();

    // Power-up sweep: 16 busy cycles.
    nb = 0;
    for (int i = 0; i < 40 && busy[0]; i++) begin
      nb++;
      cyc();
    end
    chk("busy_len_reset", 32'(nb), 32'd16);

    for (int a = 0; a < DEPTH; a++) begin
      set_in(1, 0, 4'(a), 0, 1, 0, 4'(15 - a), 0);
      cyc();
    end
    idle(); cyc(); cyc();

    // Write A:5 then read B:5.
    set_in(1, 1, 5, 8'h3C, 0, 0, 0, 0); cyc();
    set_in(0, 0, 0, 0, 1, 0, 5, 0); cyc();
    chk("rd_b5_bypass", 32'(doutb[0]), 32'h3C);
    chk("vld_b5_bypass", 32'(validb[0]), 32'd1);
    idle(); cyc();
    chk("rd_b5_pipe", 32'(doutb[1]), 32'h3C);
    chk("vld_b5_pipe", 32'(validb[1]), 32'd1);
    cyc();

    // Same-address double write.
    set_in(1, 1, 7, 8'h11, 1, 1, 7, 8'h22); cyc();
    chk("coll_pulse", 32'(coll[0]), 32'd1);
    idle(); cyc();
    chk("coll_drop", 32'(coll[0]), 32'd0);
    set_in(1, 0, 7, 0, 0, 0, 0, 0); cyc();
    chk("coll_a_wins", 32'(douta[0]), 32'h11);
    idle(); cyc();

    // Write vs read on the same address.
    set_in(1, 1, 9, 8'h00, 0, 0, 0, 0); cyc();
    set_in(1, 1, 9, 8'h55, 1, 0, 9, 0); cyc();
    chk("rw_old_word", 32'(doutb[0]), 32'h00);
    chk("rw_no_coll", 32'(coll[0]), 32'd0);
    set_in(0, 0, 0, 0, 1, 0, 9, 0); cyc();
    chk("rw_new_word", 32'(doutb[0]), 32'h55);
    idle(); cyc();

    // Same-port write modes.
    set_in(1, 1, 3, 8'h0F, 0, 0, 0, 0); cyc();
    set_in(1, 1, 3, 8'hF0, 0, 0, 0, 0); cyc();
    chk("rbw_dout", 32'(douta[0]), 32'h0F);
    chk("rbw_valid", 32'(valida[0]), 32'd1);
    chk("normal_valid", 32'(valida[2]), 32'd0);
    idle(); cyc();
    chk("thru_dout", 32'(douta[1]), 32'hF0);
    chk("thru_valid", 32'(valida[1]), 32'd1);
    cyc();

    // Random traffic with occasional clear requests.
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 3)), 8'($urandom),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 3)), 8'($urandom));
      ocea = ($urandom_range(0, 3) != 0);
      oceb = ($urandom_range(0, 3) != 0);
      clr_start = ($urandom_range(0, 63) == 0);
      cyc();
    end
    idle();
    for (int i = 0; i < 40 && clr_left > 0; i++) cyc();
    cyc();

    // Reset mid-sweep at address 8, then clr_start during CLEAR.
    clr_start = 1'b1; cyc();
    clr_start = 1'b0;
    for (int i = 0; i < 8; i++) cyc();
    do_reset();
    nb = 0;
    for (int i = 0; i < 40 && busy[0]; i++) begin
      clr_start = (i == 0 || i == 5);
      nb++;
      cyc();
    end
    clr_start = 1'b0;
    chk("busy_len_restart", 32'(nb), 32'd16);
    for (int a = 0; a < DEPTH; a++) begin
      set_in(1, 0, 4'(a), 0, 1, 0, 4'(a), 0);
      cyc();
    end
    idle(); cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
